// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with one 32-bit word per line between IF and memory.
// Hits answer one cycle after the request; misses fetch one word, fill the line, then answer.
module icache_direct #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] pc_cache,
    input  logic        pc_flag,
    output logic [31:0] ins_ori,
    output logic        ins_ori_flag,
    input  logic        jp_ok,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        mem_done
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FETCH     = 2'd1;
    localparam logic [1:0] S_FLUSHWAIT = 2'd2;

    logic [1:0]          state;
    logic                drop;
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;
    logic                  unused_pc_bits;

    assign req_idx  = pc_cache[INDEX_BITS+1:2];
    assign req_tag  = pc_cache[31:INDEX_BITS+2];
    // mem_addr doubles as the latched request PC, so the fill uses its fields
    assign fill_idx = mem_addr[INDEX_BITS+1:2];
    assign fill_tag = mem_addr[31:INDEX_BITS+2];
    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept   = pc_flag && !jp_ok;
    assign fill     = rdy && mem_done && (state != S_IDLE);
    assign unused_pc_bits = ^pc_cache[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            drop         <= 1'b0;
            ins_ori      <= '0;
            ins_ori_flag <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
        end else if (rdy) begin
            ins_ori_flag <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            ins_ori      <= data_mem[req_idx];
                            ins_ori_flag <= 1'b1;
                        end else begin
                            mem_addr <= {pc_cache[31:2], 2'b00};
                            mem_req  <= 1'b1;
                            drop     <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH, S_FLUSHWAIT: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        state   <= S_IDLE;
                        // a redirect arriving with the fill still cancels the answer
                        if (!drop && !jp_ok) begin
                            ins_ori      <= mem_ins;
                            ins_ori_flag <= 1'b1;
                        end
                    end else if (jp_ok) begin
                        drop  <= 1'b1;
                        state <= S_FLUSHWAIT;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_ins;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: vector table plus corner-case sequences,
// responses checked against a queue of expected instruction words.
module tb_icache_direct;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [31:0] pc_cache;
    logic        pc_flag;
    logic [31:0] ins_ori;
    logic        ins_ori_flag;
    logic        jp_ok;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_ins;
    logic        mem_done;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int mem_cnt  = 0;
    logic [31:0] sb[$];

    localparam int MEM_LAT = 4;

    icache_direct #(.INDEX_BITS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .pc_cache     (pc_cache),
        .pc_flag      (pc_flag),
        .ins_ori      (ins_ori),
        .ins_ori_flag (ins_ori_flag),
        .jp_ok        (jp_ok),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ins      (mem_ins),
        .mem_done     (mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0)   return 32'h0050_0093;
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory controller model, gated by rdy like the real one
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_cnt  = 0;
            mem_done = 1'b0;
        end else if (rdy) begin
            if (mem_done) begin
                mem_done = 1'b0;
                mem_cnt  = 0;
            end else if (mem_req) begin
                mem_cnt++;
                if (mem_cnt == MEM_LAT) begin
                    mem_done = 1'b1;
                    mem_ins  = mem_val(mem_addr);
                end
            end
        end
    end

    // Response monitor: every enabled edge that leaves ins_ori_flag high is one pulse
    always @(posedge clk) begin
        logic en;
        logic [31:0] exp;
        en = rdy && rst_n;
        #1;
        if (en && ins_ori_flag) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got ins_ori=%h expected no pulse", ins_ori);
            end else begin
                exp = sb.pop_front();
                check("resp_data", ins_ori, exp);
            end
        end
    end

    task automatic issue(input logic [31:0] pc, input bit respond, input logic [31:0] exp_data);
        @(negedge clk);
        pc_cache = pc;
        pc_flag  = 1'b1;
        if (respond) sb.push_back(exp_data);
        @(negedge clk);
        pc_flag = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mem_req) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        check("drain_no_timeout", 32'(n >= 60), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          hit;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0000, 1'b1, 32'h0};
        vecs[2]  = '{32'h0000_0406, 1'b0, 32'h0000_0404};
        vecs[3]  = '{32'h0000_0404, 1'b1, 32'h0};
        vecs[4]  = '{32'h0000_0004, 1'b0, 32'h0000_0004};
        vecs[5]  = '{32'h0000_0404, 1'b0, 32'h0000_0404};
        vecs[6]  = '{32'h0000_0004, 1'b0, 32'h0000_0004};
        vecs[7]  = '{32'h0000_0000, 1'b1, 32'h0};
        vecs[8]  = '{32'h0000_03FC, 1'b0, 32'h0000_03FC};
        vecs[9]  = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};
        vecs[10] = '{32'hFFFF_FFFE, 1'b1, 32'h0};

        rst_n    = 1'b0;
        rdy      = 1'b1;
        pc_flag  = 1'b0;
        jp_ok    = 1'b0;
        pc_cache = '0;
        mem_ins  = '0;
        mem_done = 1'b0;
        #1;
        check("rst_ins_ori", ins_ori, 32'h0);
        check("rst_flag", 32'(ins_ori_flag), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            p0 = pulses;
            issue(vecs[i].pc, 1'b1, mem_val({vecs[i].pc[31:2], 2'b00}));
            check("vec_mem_req", 32'(mem_req), 32'(!vecs[i].hit));
            if (!vecs[i].hit) check("vec_mem_addr", mem_addr, vecs[i].addr);
            drain();
            check("vec_pulse_count", 32'(pulses - p0), 32'd1);
        end

        // pc_flag together with jp_ok is ignored
        p0 = pulses;
        @(negedge clk);
        pc_cache = 32'h0000_0200;
        pc_flag  = 1'b1;
        jp_ok    = 1'b1;
        @(negedge clk);
        pc_flag = 1'b0;
        jp_ok   = 1'b0;
        check("jp_pcflag_no_req", 32'(mem_req), 32'd0);
        repeat (3) @(negedge clk);
        check("jp_pcflag_no_pulse", 32'(pulses - p0), 32'd0);

        // redirect during fetch: fill completes, answer dropped
        p0 = pulses;
        issue(32'h0000_0100, 1'b0, 32'h0);
        check("redir_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        jp_ok = 1'b1;
        @(negedge clk);
        jp_ok = 1'b0;
        drain();
        check("redir_no_pulse", 32'(pulses - p0), 32'd0);
        issue(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
        check("redir_refetch_hit", 32'(mem_req), 32'd0);
        drain();
        check("redir_hit_pulse", 32'(pulses - p0), 32'd1);

        // rdy low across a hit cycle
        p0 = pulses;
        @(negedge clk);
        pc_cache = 32'h0;
        pc_flag  = 1'b1;
        rdy      = 1'b0;
        sb.push_back(mem_val(32'h0));
        repeat (3) begin
            @(negedge clk);
            check("stall_flag_low", 32'(ins_ori_flag), 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        pc_flag = 1'b0;
        check("stall_flag_high", 32'(ins_ori_flag), 32'd1);
        @(negedge clk);
        check("stall_flag_cleared", 32'(ins_ori_flag), 32'd0);
        check("stall_one_pulse", 32'(pulses - p0), 32'd1);

        // rdy low in the middle of a fetch
        issue(32'h0000_0300, 1'b1, mem_val(32'h0000_0300));
        check("stall_fetch_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rdy = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_fetch_hold_req", 32'(mem_req), 32'd1);
        check("stall_fetch_hold_addr", mem_addr, 32'h0000_0300);
        rdy = 1'b1;
        drain();

        // reset in the middle of a fetch
        p0 = pulses;
        issue(32'h0000_0500, 1'b0, 32'h0);
        check("rst_fetch_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_mem_req", 32'(mem_req), 32'd0);
        check("rst_async_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
        check("post_rst_miss", 32'(mem_req), 32'd1);
        check("post_rst_addr", mem_addr, 32'h0000_0100);
        drain();
        check("post_rst_pulse", 32'(pulses - p0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
